// File: rtl/sd_bd_fetch.sv
// sd_bd_fetch: consumer side of the buffer-descriptor queue (32-bit memory mode).
// Pops one two-word BD, runs a data-engine transfer with retries, then returns the slot.
module sd_bd_fetch #(
    parameter int BD_WIDTH  = 8,
    parameter int BD_NUM    = 128,
    parameter int MAX_RETRY = 2,
    parameter int TIMEOUT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [BD_WIDTH-1:0] free_bd,
    output logic                re_s,
    input  logic [31:0]         dat_out_s,
    output logic                a_cmp,
    output logic                xfer_start,
    output logic [31:0]         xfer_sys_addr,
    output logic [31:0]         xfer_blk_addr,
    input  logic                xfer_done,
    input  logic                xfer_err,
    output logic                bd_done,
    output logic                bd_err,
    output logic [1:0]          err_code,
    output logic                busy
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [BD_WIDTH:0]  BD_NUM_L    = (BD_WIDTH + 1)'(BD_NUM);
    localparam logic [BD_WIDTH:0]  BD_ONE      = (BD_WIDTH + 1)'(1'b1);
    localparam logic [RW-1:0]      MAX_RETRY_L = RW'(MAX_RETRY);
    localparam logic [RW-1:0]      RETRY_ONE   = RW'(1'b1);
    localparam logic [TIMEOUT_W-1:0] WD_ONE    = TIMEOUT_W'(1'b1);
    localparam logic [1:0] EC_OK   = 2'b00;
    localparam logic [1:0] EC_XFER = 2'b01;
    localparam logic [1:0] EC_TMO  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD0   = 3'd1,
        ST_RD1   = 3'd2,
        ST_LATCH = 3'd3,
        ST_START = 3'd4,
        ST_WAIT  = 3'd5,
        ST_CMP   = 3'd6,
        ST_CHK   = 3'd7
    } state_t;

    state_t               state_r;
    state_t               next_state_s;
    logic [TIMEOUT_W-1:0] wd_r;
    logic [RW-1:0]        retry_cnt_r;
    logic [BD_WIDTH-1:0]  cap_r;
    logic [1:0]           err_code_r;
    logic [31:0]          sys_addr_r;
    logic [31:0]          blk_addr_r;
    logic                 re_r;
    logic                 a_cmp_r;
    logic                 start_r;
    logic                 bd_done_r;
    logic                 bd_err_r;
    logic                 busy_r;

    logic pending_s;
    logic in_wait_s;
    logic ok_s;
    logic xerr_s;
    logic tmo_s;
    logic fail_s;
    logic can_retry_s;
    logic returned_s;
    logic re_nx_s;
    logic a_cmp_nx_s;
    logic start_nx_s;
    logic bd_done_nx_s;
    logic bd_err_nx_s;
    logic busy_nx_s;

    // Attempt outcome and slot-return decode; xfer_err wins over a coincident xfer_done.
    always_comb begin
        pending_s   = enable && ({1'b0, free_bd} < BD_NUM_L);
        in_wait_s   = (state_r == ST_WAIT);
        xerr_s      = in_wait_s && xfer_err;
        ok_s        = in_wait_s && xfer_done && !xfer_err;
        tmo_s       = in_wait_s && !xfer_done && !xfer_err && (wd_r == {TIMEOUT_W{1'b0}});
        fail_s      = xerr_s || tmo_s;
        can_retry_s = (retry_cnt_r < MAX_RETRY_L);
        returned_s  = ({1'b0, free_bd} == ({1'b0, cap_r} + BD_ONE));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pending_s) begin
                    next_state_s = ST_RD0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RD0:   next_state_s = ST_RD1;
            ST_RD1:   next_state_s = ST_LATCH;
            ST_LATCH: next_state_s = ST_START;
            ST_START: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (ok_s) begin
                    next_state_s = ST_CMP;
                end else if (fail_s) begin
                    if (can_retry_s) begin
                        next_state_s = ST_START;
                    end else begin
                        next_state_s = ST_CMP;
                    end
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_CMP:   next_state_s = ST_CHK;
            // A queue write landing with a_cmp hides the increment; pulse a_cmp again.
            ST_CHK: begin
                if (returned_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_CMP;
                end
            end
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the state being entered, so the registered pulses line up with it.
    always_comb begin
        re_nx_s      = (next_state_s == ST_RD0) || (next_state_s == ST_RD1);
        a_cmp_nx_s   = (next_state_s == ST_CMP);
        start_nx_s   = (next_state_s == ST_START);
        busy_nx_s    = (next_state_s != ST_IDLE);
        bd_done_nx_s = (state_r == ST_CHK) && returned_s && (err_code_r == EC_OK);
        bd_err_nx_s  = (state_r == ST_CHK) && returned_s && (err_code_r != EC_OK);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            re_r      <= 1'b0;
            a_cmp_r   <= 1'b0;
            start_r   <= 1'b0;
            bd_done_r <= 1'b0;
            bd_err_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            re_r      <= re_nx_s;
            a_cmp_r   <= a_cmp_nx_s;
            start_r   <= start_nx_s;
            bd_done_r <= bd_done_nx_s;
            bd_err_r  <= bd_err_nx_s;
            busy_r    <= busy_nx_s;
        end
    end

    // BD words, watchdog, retry count, error code and free-count snapshot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sys_addr_r  <= 32'h0000_0000;
            blk_addr_r  <= 32'h0000_0000;
            err_code_r  <= EC_OK;
            retry_cnt_r <= {RW{1'b0}};
            wd_r        <= {TIMEOUT_W{1'b0}};
            cap_r       <= {BD_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_RD1: sys_addr_r <= dat_out_s;
                ST_LATCH: begin
                    blk_addr_r  <= dat_out_s;
                    err_code_r  <= EC_OK;
                    retry_cnt_r <= {RW{1'b0}};
                end
                ST_START: wd_r <= {TIMEOUT_W{1'b1}};
                ST_WAIT: begin
                    if (ok_s) begin
                        err_code_r <= EC_OK;
                    end else if (fail_s) begin
                        err_code_r <= xerr_s ? EC_XFER : EC_TMO;
                        if (can_retry_s) begin
                            retry_cnt_r <= retry_cnt_r + RETRY_ONE;
                        end else begin
                            retry_cnt_r <= retry_cnt_r;
                        end
                    end else begin
                        wd_r <= wd_r - WD_ONE;
                    end
                end
                ST_CMP:  cap_r <= free_bd;
                default: cap_r <= cap_r;
            endcase
        end
    end

    assign re_s          = re_r;
    assign a_cmp         = a_cmp_r;
    assign xfer_start    = start_r;
    assign bd_done       = bd_done_r;
    assign bd_err        = bd_err_r;
    assign busy          = busy_r;
    assign err_code      = err_code_r;
    assign xfer_sys_addr = sys_addr_r;
    assign xfer_blk_addr = blk_addr_r;

endmodule

// File: tb/tb_sd_bd_fetch.sv
// Bench for sd_bd_fetch: a cycle timeline is planned from the BD rules, then replayed and compared.
// A second instance with a 4-bit watchdog exercises the timeout path.
module tb_sd_bd_fetch;
    localparam int NC = 140;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, re_s, a_cmp, xfer_start, xfer_done, xfer_err, bd_done, bd_err, busy;
    logic [7:0]  free_bd;
    logic [31:0] dat_out_s, xfer_sys_addr, xfer_blk_addr;
    logic [1:0]  err_code;

    logic        t_rst, t_en, t_re, t_cmp, t_start, t_done, t_err, t_bdone, t_berr, t_busy;
    logic [7:0]  t_free;
    logic [31:0] t_dat, t_sys, t_blk;
    logic [1:0]  t_ec;

    sd_bd_fetch u_dut (
        .clk(clk), .rst(rst), .enable(enable), .free_bd(free_bd), .re_s(re_s),
        .dat_out_s(dat_out_s), .a_cmp(a_cmp), .xfer_start(xfer_start),
        .xfer_sys_addr(xfer_sys_addr), .xfer_blk_addr(xfer_blk_addr),
        .xfer_done(xfer_done), .xfer_err(xfer_err), .bd_done(bd_done), .bd_err(bd_err),
        .err_code(err_code), .busy(busy)
    );

    sd_bd_fetch #(.TIMEOUT_W(4)) u_to (
        .clk(clk), .rst(t_rst), .enable(t_en), .free_bd(t_free), .re_s(t_re),
        .dat_out_s(t_dat), .a_cmp(t_cmp), .xfer_start(t_start),
        .xfer_sys_addr(t_sys), .xfer_blk_addr(t_blk),
        .xfer_done(t_done), .xfer_err(t_err), .bd_done(t_bdone), .bd_err(t_berr),
        .err_code(t_ec), .busy(t_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit to_finished = 1'b0;

    logic        in_rst[NC], in_en[NC], in_done[NC], in_err[NC];
    logic [7:0]  in_free[NC];
    logic [31:0] in_dat[NC];
    logic        ex_re[NC], ex_cmp[NC], ex_start[NC], ex_done[NC], ex_berr[NC], ex_busy[NC];
    bit          chk_a[NC], chk_e[NC];
    logic [31:0] ex_sys[NC], ex_blk[NC];
    logic [1:0]  ex_ec[NC];

    int start_q[$];
    int done_q[$];
    int cmp_q[$];
    int n_re = 0;
    int n_berr = 0;

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, c, act, exp);
        end
    endtask

    task automatic fill_free(input int c, input logic [7:0] v);
        for (int i = c; i < NC; i++) in_free[i] = v;
    endtask

    task automatic fill_en(input int c, input logic v);
        for (int i = c; i < NC; i++) in_en[i] = v;
    endtask

    task automatic want_words(input int a, input int b, input logic [31:0] w0, input logic [31:0] w1);
        for (int x = a; x <= b; x++) begin
            chk_a[x] = 1'b1; ex_sys[x] = w0; ex_blk[x] = w1;
        end
    endtask

    // One BD seen pending at cycle t; attempt k fails when errs[k], responses come dly cycles after launch.
    task automatic plan_bd(input int t, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [2:0] errs, input int dly, input bit lost, output int t_end);
        int s, c, chk;
        logic [7:0] fb;
        logic [1:0] code;
        ex_re[t+1] = 1'b1; ex_re[t+2] = 1'b1;
        in_dat[t+2] = w0; in_dat[t+3] = w1;
        s = t + 4; code = 2'b00;
        for (int k = 0; k <= 2; k++) begin
            ex_start[s] = 1'b1;
            if (errs[k]) begin in_err[s+dly] = 1'b1; code = 2'b01; end
            else begin in_done[s+dly] = 1'b1; code = 2'b00; end
            s = s + dly + 1;
            if (!errs[k]) break;
        end
        c = s;
        fb = in_free[c];
        ex_cmp[c] = 1'b1;
        if (lost) begin
            fill_free(c + 1, fb - 8'd1);
            ex_cmp[c+2] = 1'b1;
            fill_free(c + 3, fb);
            chk = c + 3;
        end else begin
            fill_free(c + 1, fb + 8'd1);
            chk = c + 1;
        end
        for (int x = t + 1; x <= chk; x++) ex_busy[x] = 1'b1;
        if (code == 2'b00) ex_done[chk+1] = 1'b1;
        else ex_berr[chk+1] = 1'b1;
        want_words(t + 4, chk + 1, w0, w1);
        chk_e[t+4] = 1'b1; ex_ec[t+4] = 2'b00;
        chk_e[chk+1] = 1'b1; ex_ec[chk+1] = code;
        t_end = chk + 1;
    endtask

    // BD that is cut off by a two-cycle reset while waiting for the data engine.
    task automatic plan_abort(input int t, input logic [31:0] w0, input logic [31:0] w1, output int t_end);
        int s;
        ex_re[t+1] = 1'b1; ex_re[t+2] = 1'b1;
        in_dat[t+2] = w0; in_dat[t+3] = w1;
        s = t + 4;
        ex_start[s] = 1'b1;
        for (int x = t + 1; x <= s + 3; x++) ex_busy[x] = 1'b1;
        want_words(s, s + 3, w0, w1);
        chk_e[s] = 1'b1; ex_ec[s] = 2'b00;
        in_rst[s+3] = 1'b0; in_rst[s+4] = 1'b0;
        want_words(s + 4, s + 5, 32'h0000_0000, 32'h0000_0000);
        chk_e[s+4] = 1'b1; ex_ec[s+4] = 2'b00;
        chk_e[s+5] = 1'b1; ex_ec[s+5] = 2'b00;
        t_end = s + 5;
    endtask

    initial begin
        int te;
        for (int i = 0; i < NC; i++) begin
            in_rst[i] = (i >= 2); in_en[i] = 1'b0; in_done[i] = 1'b0; in_err[i] = 1'b0;
            in_free[i] = 8'd128; in_dat[i] = 32'h0000_0000;
            ex_re[i] = 1'b0; ex_cmp[i] = 1'b0; ex_start[i] = 1'b0; ex_done[i] = 1'b0;
            ex_berr[i] = 1'b0; ex_busy[i] = 1'b0; chk_a[i] = 1'b0; chk_e[i] = 1'b0;
            ex_sys[i] = 32'h0000_0000; ex_blk[i] = 32'h0000_0000; ex_ec[i] = 2'b00;
        end
        chk_a[0] = 1'b1; chk_e[0] = 1'b1;

        fill_en(4, 1'b1); fill_free(4, 8'd127);
        plan_abort(4, 32'hAAAA_0001, 32'hBBBB_0002, te);
        plan_bd(te, 32'h1000_0000, 32'h0000_0200, 3'b000, 5, 1'b0, te);
        fill_free(30, 8'd126);
        plan_bd(30, 32'h2000_0040, 32'h0000_1000, 3'b011, 3, 1'b0, te);
        fill_en(33, 1'b0);
        fill_en(58, 1'b1);
        plan_bd(58, 32'h3000_0080, 32'h0000_2000, 3'b111, 2, 1'b0, te);
        fill_free(78, 8'd127);
        plan_bd(78, 32'h4000_00C0, 32'h0000_3000, 3'b000, 4, 1'b1, te);
        fill_en(te, 1'b0);
        fill_en(96, 1'b1); fill_free(96, 8'd126);
        plan_bd(96, 32'h5000_0100, 32'h0000_4000, 3'b000, 3, 1'b0, te);
        plan_bd(te, 32'h6000_0140, 32'h0000_5000, 3'b000, 3, 1'b0, te);
        fill_en(te, 1'b0);
        fill_free(te + 2, 8'd120);

        rst = 1'b0; enable = 1'b0; free_bd = 8'd128; dat_out_s = 32'h0000_0000;
        xfer_done = 1'b0; xfer_err = 1'b0;
        @(posedge clk);
        for (int c = 0; c < NC; c++) begin
            #1;
            check("re_s", c, re_s, ex_re[c]);
            check("a_cmp", c, a_cmp, ex_cmp[c]);
            check("xfer_start", c, xfer_start, ex_start[c]);
            check("bd_done", c, bd_done, ex_done[c]);
            check("bd_err", c, bd_err, ex_berr[c]);
            check("busy", c, busy, ex_busy[c]);
            if (chk_a[c]) begin
                check("sys_addr", c, xfer_sys_addr, ex_sys[c]);
                check("blk_addr", c, xfer_blk_addr, ex_blk[c]);
            end
            if (chk_e[c]) check("err_code", c, err_code, ex_ec[c]);
            if (re_s === 1'b1) n_re++;
            if (xfer_start === 1'b1) start_q.push_back(c);
            if (bd_done === 1'b1) done_q.push_back(c);
            if (a_cmp === 1'b1) cmp_q.push_back(c);
            if (bd_err === 1'b1) n_berr++;
            rst = in_rst[c]; enable = in_en[c]; free_bd = in_free[c]; dat_out_s = in_dat[c];
            xfer_done = in_done[c]; xfer_err = in_err[c];
            @(posedge clk);
        end

        check("total_re_s", 0, n_re, 14);
        check("total_xfer_start", 0, start_q.size(), 11);
        check("total_a_cmp", 0, cmp_q.size(), 7);
        check("total_bd_done", 0, done_q.size(), 5);
        check("total_bd_err", 0, n_berr, 1);
        check("abort_start_cyc", 0, (start_q.size() > 0) ? start_q[0] : -1, 8);
        check("success_start_cyc", 0, (start_q.size() > 1) ? start_q[1] : -1, 17);
        check("success_cmp_cyc", 0, (cmp_q.size() > 0) ? cmp_q[0] : -1, 23);
        check("success_done_cyc", 0, (done_q.size() > 0) ? done_q[0] : -1, 25);

        for (int i = 0; i < 400 && !to_finished; i++) @(posedge clk);
        check("timeout_run_finished", 0, to_finished, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog instance: no engine response at all; the queue returns the slot after each a_cmp.
    initial begin
        int first_s, second_s, err_c, ns;
        logic [1:0] ec_at;
        bit inc;
        t_rst = 1'b0; t_en = 1'b0; t_free = 8'd128; t_dat = 32'h0000_0000;
        t_done = 1'b0; t_err = 1'b0;
        first_s = -1; second_s = -1; err_c = -1; ns = 0; ec_at = 2'b00; inc = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        t_rst = 1'b1; t_en = 1'b1; t_free = 8'd127;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk); #1;
            if (inc) t_free = t_free + 8'd1;
            inc = (t_cmp === 1'b1);
            if (t_start === 1'b1) begin
                ns++;
                if (first_s < 0) first_s = c;
                else if (second_s < 0) second_s = c;
            end
            if (t_berr === 1'b1 && err_c < 0) begin
                err_c = c; ec_at = t_ec; t_en = 1'b0;
            end
        end
        check("to_starts", 0, ns, 3);
        check("to_attempt_period", 0, second_s - first_s, 17);
        check("to_bd_err_latency", 0, err_c - first_s, 53);
        check("to_err_code", 0, ec_at, 2'b10);
        to_finished = 1'b1;
    end

endmodule
